// File: rtl/status_led_pkg.sv
// Shared types and constants for the FPGA status LED controller.
// Used by fpga_status_led_ctrl and status_blinkcode_gen.
package status_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF       = 2'b00,
        LED_HEARTBEAT = 2'b01,
        LED_PWM       = 2'b10,
        LED_EXIT      = 2'b11
    } led_mode_e;

    typedef enum logic [1:0] {
        BLINK_IDLE = 2'b00,
        BLINK_ON   = 2'b01,
        BLINK_OFF  = 2'b10,
        BLINK_GAP  = 2'b11
    } blink_state_e;

    localparam int BLINK_GAP_TICKS = 4;
    localparam int PULSE_CNT_W     = 5;
    localparam int GAP_CNT_W       = 3;

    // A code of zero is shown as 16 pulses so that it remains visible.
    function automatic logic [PULSE_CNT_W-1:0] blink_pulse_count(input logic [3:0] code);
        return (code == 4'd0) ? PULSE_CNT_W'(16) : {1'b0, code};
    endfunction

endpackage

// File: rtl/status_blinkcode_gen.sv
// Blink-code generator: emits n pulses of one tick each, then a gap, repeating.
// Only instantiated when STATUS_LED_BLINKCODE_EN is defined.
module status_blinkcode_gen
    import status_led_pkg::*;
(
    input  logic       clk_gen,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       clear,
    input  logic [3:0] code,
    output logic       blink_o
);

    blink_state_e               state, state_nxt;
    logic [PULSE_CNT_W-1:0]     pulses_left, pulses_nxt;
    logic [GAP_CNT_W-1:0]       gap_cnt, gap_nxt;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLINK_IDLE;
            pulses_left <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            pulses_left <= pulses_nxt;
            gap_cnt     <= gap_nxt;
        end
    end

    // pulses_left counts the pulses still to come after the current ON phase.
    always_comb begin
        state_nxt  = state;
        pulses_nxt = pulses_left;
        gap_nxt    = gap_cnt;
        if (clear) begin
            state_nxt  = BLINK_IDLE;
            pulses_nxt = '0;
            gap_nxt    = '0;
        end else if (tick) begin
            case (state)
                BLINK_IDLE: begin
                    if (start) begin
                        state_nxt  = BLINK_ON;
                        pulses_nxt = blink_pulse_count(code) - PULSE_CNT_W'(1);
                    end
                end
                BLINK_ON: state_nxt = BLINK_OFF;
                BLINK_OFF: begin
                    if (pulses_left != '0) begin
                        state_nxt  = BLINK_ON;
                        pulses_nxt = pulses_left - PULSE_CNT_W'(1);
                    end else begin
                        state_nxt = BLINK_GAP;
                        gap_nxt   = '0;
                    end
                end
                BLINK_GAP: begin
                    if (gap_cnt == GAP_CNT_W'(BLINK_GAP_TICKS - 1)) begin
                        state_nxt  = BLINK_ON;
                        pulses_nxt = blink_pulse_count(code) - PULSE_CNT_W'(1);
                        gap_nxt    = '0;
                    end else begin
                        gap_nxt = gap_cnt + GAP_CNT_W'(1);
                    end
                end
                default: state_nxt = BLINK_IDLE;
            endcase
        end
    end

    assign blink_o = (state == BLINK_ON);

endmodule

// File: rtl/fpga_status_led_ctrl.sv
// Multi-mode board status LEDs (off / heartbeat / PWM / exit status) with sticky exit latch.
// Define STATUS_LED_BLINKCODE_EN to show failing exit codes as a blink code instead of a square wave.
module fpga_status_led_ctrl
    import status_led_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int CNT_W    = 27,
    parameter int TICK_W   = 22,
    parameter int PWM_W    = 4,
    parameter int EXIT_W   = 32
) (
    input  logic                  clk_gen,
    input  logic                  rst_n,
    input  logic [2*NUM_LEDS-1:0] mode_i,
    input  logic [PWM_W-1:0]      duty_i,
    input  logic                  exit_valid_i,
    input  logic [EXIT_W-1:0]     exit_value_i,
    input  logic                  exit_clear_i,
    output logic [NUM_LEDS-1:0]   led_o,
    output logic                  exit_latched_o,
    output logic                  exit_pass_o
);

    logic [CNT_W-1:0]    clk_count;
    logic [EXIT_W-1:0]   exit_code;
    logic                fail_pattern;
    logic [NUM_LEDS-1:0] led_nxt;
    logic                unused_bits;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            clk_count <= '0;
        end else begin
            clk_count <= clk_count + CNT_W'(1);
        end
    end

    // Clear has priority; a still-asserted valid recaptures on the following cycle.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            exit_latched_o <= 1'b0;
            exit_pass_o    <= 1'b0;
            exit_code      <= '0;
        end else if (exit_clear_i) begin
            exit_latched_o <= 1'b0;
            exit_pass_o    <= 1'b0;
        end else if (!exit_latched_o && exit_valid_i) begin
            exit_latched_o <= 1'b1;
            exit_pass_o    <= (exit_value_i == '0);
            exit_code      <= exit_value_i;
        end
    end

`ifdef STATUS_LED_BLINKCODE_EN
    logic tick;

    assign tick = &clk_count[TICK_W-1:0];

    status_blinkcode_gen u_blinkcode (
        .clk_gen (clk_gen),
        .rst_n   (rst_n),
        .tick    (tick),
        .start   (exit_latched_o && !exit_pass_o),
        .clear   (exit_clear_i),
        .code    (exit_code[3:0]),
        .blink_o (fail_pattern)
    );
`else
    assign fail_pattern = clk_count[TICK_W];
`endif

    assign unused_bits = ^{clk_count, exit_code};

    always_comb begin
        led_nxt = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            case (led_mode_e'(mode_i[2*k +: 2]))
                LED_OFF:       led_nxt[k] = 1'b0;
                LED_HEARTBEAT: led_nxt[k] = clk_count[CNT_W-1];
                LED_PWM:       led_nxt[k] = (clk_count[PWM_W-1:0] < duty_i);
                LED_EXIT:      led_nxt[k] = exit_latched_o && (exit_pass_o || fail_pattern);
                default:       led_nxt[k] = 1'b0;
            endcase
        end
    end

    // Output register stage
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            led_o <= '0;
        end else begin
            led_o <= led_nxt;
        end
    end

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Directed bench for fpga_status_led_ctrl with CNT_W=8, TICK_W=3, PWM_W=4, NUM_LEDS=4.
// Blink-code checks run when STATUS_LED_BLINKCODE_EN is defined, square-wave checks otherwise.
module tb_fpga_status_led_ctrl;

    localparam int NUM_LEDS = 4;
    localparam int CNT_W    = 8;
    localparam int TICK_W   = 3;
    localparam int PWM_W    = 4;
    localparam int EXIT_W   = 32;

    logic                  clk_gen;
    logic                  rst_n;
    logic [2*NUM_LEDS-1:0] mode_i;
    logic [PWM_W-1:0]      duty_i;
    logic                  exit_valid_i;
    logic [EXIT_W-1:0]     exit_value_i;
    logic                  exit_clear_i;
    logic [NUM_LEDS-1:0]   led_o;
    logic                  exit_latched_o;
    logic                  exit_pass_o;

    int total;
    int bad;

    fpga_status_led_ctrl #(
        .NUM_LEDS (NUM_LEDS),
        .CNT_W    (CNT_W),
        .TICK_W   (TICK_W),
        .PWM_W    (PWM_W),
        .EXIT_W   (EXIT_W)
    ) dut (
        .clk_gen        (clk_gen),
        .rst_n          (rst_n),
        .mode_i         (mode_i),
        .duty_i         (duty_i),
        .exit_valid_i   (exit_valid_i),
        .exit_value_i   (exit_value_i),
        .exit_clear_i   (exit_clear_i),
        .led_o          (led_o),
        .exit_latched_o (exit_latched_o),
        .exit_pass_o    (exit_pass_o)
    );

    initial clk_gen = 1'b0;
    always #5 clk_gen = ~clk_gen;

    // One clock; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk_gen);
        @(negedge clk_gen);
    endtask

    // After this returns, the k-th following step leaves clk_count == k.
    task automatic apply_reset(input logic [7:0] mode, input logic [3:0] duty);
        rst_n        = 1'b0;
        mode_i       = mode;
        duty_i       = duty;
        exit_valid_i = 1'b0;
        exit_value_i = '0;
        exit_clear_i = 1'b0;
        @(negedge clk_gen);
        @(negedge clk_gen);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        mode_i       = 8'h55;
        duty_i       = 4'd4;
        exit_valid_i = 1'b1;
        exit_value_i = '0;
        exit_clear_i = 1'b0;
        repeat (3) @(negedge clk_gen);
        total++;
        if (led_o !== 4'h0) begin
            bad++; $display("FAIL reset_led got=%h want=0", led_o);
        end
        total++;
        if (exit_latched_o !== 1'b0) begin
            bad++; $display("FAIL reset_latched got=%b want=0", exit_latched_o);
        end
        total++;
        if (exit_pass_o !== 1'b0) begin
            bad++; $display("FAIL reset_pass got=%b want=0", exit_pass_o);
        end
        exit_valid_i = 1'b0;
    endtask

    task automatic test_heartbeat();
        logic [3:0] exp;
        apply_reset(8'h55, 4'd0);
        for (int k = 1; k <= 512; k++) begin
            step();
            exp = (((k - 1) >> 7) & 1) != 0 ? 4'hF : 4'h0;
            total++;
            if (led_o !== exp) begin
                bad++; $display("FAIL heartbeat cyc=%0d got=%h want=%h", k, led_o, exp);
            end
        end
    endtask

    task automatic test_pwm();
        int k;
        int highs;
        logic exp;
        apply_reset(8'h02, 4'd4);
        k = 0;
        highs = 0;
        for (int i = 0; i < 64; i++) begin
            step(); k++;
            exp = ((k - 1) % 16) < 4;
            if (k >= 17 && k <= 32 && led_o[0]) highs++;
            total++;
            if (led_o !== {3'b000, exp}) begin
                bad++; $display("FAIL pwm_duty4 cyc=%0d got=%h want=%h", k, led_o, {3'b000, exp});
            end
        end
        total++;
        if (highs !== 4) begin
            bad++; $display("FAIL pwm_duty4_count got=%0d want=4", highs);
        end
        duty_i = 4'd0;
        for (int i = 0; i < 32; i++) begin
            step(); k++;
            total++;
            if (led_o !== 4'h0) begin
                bad++; $display("FAIL pwm_duty0 cyc=%0d got=%h want=0", k, led_o);
            end
        end
        duty_i = 4'd15;
        for (int i = 0; i < 32; i++) begin
            step(); k++;
            exp = ((k - 1) % 16) < 15;
            total++;
            if (led_o !== {3'b000, exp}) begin
                bad++; $display("FAIL pwm_duty15 cyc=%0d got=%h want=%h", k, led_o, {3'b000, exp});
            end
        end
    endtask

    task automatic test_exit_pass();
        apply_reset(8'hFF, 4'd0);
        repeat (3) step();
        total++;
        if (led_o !== 4'h0 || exit_latched_o !== 1'b0) begin
            bad++; $display("FAIL exit_idle led=%h latched=%b want led=0 latched=0", led_o, exit_latched_o);
        end
        exit_valid_i = 1'b1;
        exit_value_i = 32'd0;
        step();
        total++;
        if (exit_latched_o !== 1'b1 || exit_pass_o !== 1'b1) begin
            bad++; $display("FAIL exit_capture latched=%b pass=%b want 1 1", exit_latched_o, exit_pass_o);
        end
        total++;
        if (led_o !== 4'h0) begin
            bad++; $display("FAIL exit_led_latency got=%h want=0", led_o);
        end
        exit_value_i = 32'd5;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (led_o !== 4'hF || exit_pass_o !== 1'b1 || exit_latched_o !== 1'b1) begin
                bad++; $display("FAIL exit_pass_sticky i=%0d led=%h pass=%b latched=%b want F 1 1",
                                i, led_o, exit_pass_o, exit_latched_o);
            end
        end
        exit_valid_i = 1'b0;
        exit_value_i = '0;
    endtask

`ifndef STATUS_LED_BLINKCODE_EN
    task automatic test_exit_fail_square();
        int k;
        logic [3:0] exp;
        apply_reset(8'hFF, 4'd0);
        exit_valid_i = 1'b1;
        exit_value_i = 32'd3;
        step(); k = 1;
        total++;
        if (exit_latched_o !== 1'b1 || exit_pass_o !== 1'b0) begin
            bad++; $display("FAIL fail_capture latched=%b pass=%b want 1 0", exit_latched_o, exit_pass_o);
        end
        exit_valid_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(); k++;
            exp = (((k - 1) >> 3) & 1) != 0 ? 4'hF : 4'h0;
            total++;
            if (led_o !== exp) begin
                bad++; $display("FAIL fail_square cyc=%0d got=%h want=%h", k, led_o, exp);
            end
        end
        exit_clear_i = 1'b1;
        step();
        exit_clear_i = 1'b0;
        total++;
        if (exit_latched_o !== 1'b0 || exit_pass_o !== 1'b0) begin
            bad++; $display("FAIL fail_clear latched=%b pass=%b want 0 0", exit_latched_o, exit_pass_o);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (led_o !== 4'h0 || exit_latched_o !== 1'b0) begin
                bad++; $display("FAIL fail_after_clear i=%0d led=%h latched=%b want 0 0", i, led_o, exit_latched_o);
            end
        end
    endtask
`else
    task automatic run_blink(input logic [31:0] value, input int n, input int cycles);
        int e;
        int j;
        logic on;
        apply_reset(8'hFF, 4'd0);
        exit_valid_i = 1'b1;
        exit_value_i = value;
        step();
        total++;
        if (exit_latched_o !== 1'b1 || exit_pass_o !== 1'b0) begin
            bad++; $display("FAIL blink_capture n=%0d latched=%b pass=%b want 1 0", n, exit_latched_o, exit_pass_o);
        end
        exit_valid_i = 1'b0;
        for (int k = 2; k <= cycles; k++) begin
            step();
            e = k - 1;
            j = (e >= 8) ? ((e - 8) / 8) % (2 * n + 4) : 0;
            on = (e >= 8) && (j < 2 * n) && ((j % 2) == 0);
            total++;
            if (led_o !== {4{on}}) begin
                bad++; $display("FAIL blink n=%0d cyc=%0d got=%h want=%h", n, k, led_o, {4{on}});
            end
        end
    endtask

    task automatic test_blinkcode();
        run_blink(32'd3, 3, 240);
        run_blink(32'h10, 16, 600);
        exit_clear_i = 1'b1;
        step();
        exit_clear_i = 1'b0;
        step();
        total++;
        if (led_o !== 4'h0 || exit_latched_o !== 1'b0) begin
            bad++; $display("FAIL blink_clear led=%h latched=%b want 0 0", led_o, exit_latched_o);
        end
    endtask
`endif

    task automatic test_clear_race();
        apply_reset(8'hFF, 4'd0);
        exit_valid_i = 1'b1;
        exit_value_i = 32'd0;
        step();
        total++;
        if (exit_latched_o !== 1'b1) begin
            bad++; $display("FAIL race_first_capture got=%b want=1", exit_latched_o);
        end
        exit_value_i = 32'd7;
        exit_clear_i = 1'b1;
        step();
        total++;
        if (exit_latched_o !== 1'b0 || exit_pass_o !== 1'b0) begin
            bad++; $display("FAIL race_clear_wins latched=%b pass=%b want 0 0", exit_latched_o, exit_pass_o);
        end
        exit_clear_i = 1'b0;
        step();
        total++;
        if (exit_latched_o !== 1'b1 || exit_pass_o !== 1'b0) begin
            bad++; $display("FAIL race_recapture latched=%b pass=%b want 1 0", exit_latched_o, exit_pass_o);
        end
        exit_valid_i = 1'b0;
        repeat (4) step();
        total++;
        if (exit_latched_o !== 1'b1) begin
            bad++; $display("FAIL race_sticky got=%b want=1", exit_latched_o);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        apply_reset(8'hFF, 4'd0);
        exit_valid_i = 1'b1;
        exit_value_i = 32'd3;
        step();
        exit_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (led_o === 4'hF) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL async_wait_led_on got=%h want=F within 200 cycles", led_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (led_o !== 4'h0 || exit_latched_o !== 1'b0 || exit_pass_o !== 1'b0) begin
            bad++; $display("FAIL async_reset led=%h latched=%b pass=%b want 0 0 0",
                            led_o, exit_latched_o, exit_pass_o);
        end
        @(negedge clk_gen);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_heartbeat();
        test_pwm();
        test_exit_pass();
`ifndef STATUS_LED_BLINKCODE_EN
        test_exit_fail_square();
`else
        test_blinkcode();
`endif
        test_clear_race();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
